// File: rtl/pid_cntrl_pipe.sv
// Two-stage pipelined PID balance controller with runtime gains and a power/ramp FSM.
// Optional output slew limiting is compiled in when SLEW_LMT_EN is defined.
module pid_cntrl_pipe #(
    parameter int IN_W      = 16,
    parameter int ERR_W     = 10,
    parameter int INT_W     = 18,
    parameter int OUT_W     = 12,
    parameter int TMR_W     = 27,
    parameter int FAST_SIM  = 1,
    parameter int SLEW_STEP = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld,
    input  logic                    pwr_up,
    input  logic                    rider_off,
    input  logic signed [IN_W-1:0]  ptch,
    input  logic signed [IN_W-1:0]  ptch_rt,
    input  logic        [5:0]       kp,
    input  logic        [3:0]       d_shft,
    output logic signed [OUT_W-1:0] PID_cntrl,
    output logic                    cntrl_vld,
    output logic                    sat,
    output logic        [7:0]       ss_tmr
);

    // Handshake: vld is a single-cycle sample strobe with no back-pressure;
    // cntrl_vld is a single-cycle strobe two cycles after each accepted vld.

    localparam int P_W   = ERR_W + 7;
    localparam int D_W   = IN_W - 3;
    localparam int I_W   = INT_W - 3;
    // Kept wide enough that full-scale gains cannot wrap before saturation.
    localparam int SUM_W = (OUT_W + 4 > P_W + 2) ? OUT_W + 4 : P_W + 2;

    localparam logic [TMR_W-1:0] RAMP_STEP = (FAST_SIM != 0) ? TMR_W'(256) : TMR_W'(1);

    localparam logic signed [IN_W-1:0]  ERR_MAX = IN_W'((1 << (ERR_W - 1)) - 1);
    localparam logic signed [IN_W-1:0]  ERR_MIN = ~ERR_MAX;
    localparam logic signed [INT_W-1:0] I_MAX   = INT_W'((1 << (I_W - 1)) - 1);
    localparam logic signed [INT_W-1:0] I_MIN   = ~I_MAX;
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                  state;
    logic [TMR_W-1:0]        tmr;
    logic                    ss_full;
    logic                    active;

    logic signed [INT_W-1:0] integrator;
    logic signed [P_W-1:0]   p_reg;
    logic signed [D_W-1:0]   d_reg;
    logic                    s1_vld;

    logic signed [ERR_W-1:0] err;
    logic signed [P_W-1:0]   err_x;
    logic signed [P_W-1:0]   kp_x;
    logic signed [P_W-1:0]   p_nxt;
    logic signed [IN_W-1:0]  rt_shf;
    logic signed [D_W-1:0]   d_nxt;
    logic signed [INT_W-1:0] int_add;
    logic signed [INT_W-1:0] int_sum;
    logic                    int_ovf;

    logic signed [INT_W-1:0] int_shf;
    logic signed [I_W-1:0]   i_term;
    logic signed [SUM_W-1:0] sum;
    logic signed [OUT_W-1:0] sat_val;
    logic                    sat_clip;
    logic signed [OUT_W-1:0] out_nxt;
    logic                    sat_nxt;

    assign ss_tmr  = tmr[TMR_W-1 -: 8];
    assign ss_full = &ss_tmr;
    // Datapath runs only while powered and already out of IDLE; a falling
    // pwr_up kills the pipeline on the same edge the FSM returns to IDLE.
    assign active  = (state != IDLE) && pwr_up;

    // Stage 1 combinational terms
    always_comb begin
        if (ptch > ERR_MAX)
            err = ERR_MAX[ERR_W-1:0];
        else if (ptch < ERR_MIN)
            err = ERR_MIN[ERR_W-1:0];
        else
            err = ptch[ERR_W-1:0];
    end

    assign err_x   = P_W'(err);
    assign kp_x    = P_W'(kp);
    assign p_nxt   = err_x * kp_x;
    assign rt_shf  = ptch_rt >>> d_shft;
    assign d_nxt   = D_W'(-rt_shf);
    assign int_add = INT_W'(err);
    assign int_sum = integrator + int_add;
    assign int_ovf = (integrator[INT_W-1] == int_add[INT_W-1]) &&
                     (int_sum[INT_W-1] != integrator[INT_W-1]);

    // Integrator scaling into the I term
    always_comb begin
        if (FAST_SIM != 0) begin
            int_shf = integrator >>> 1;
            if (int_shf > I_MAX)
                i_term = I_MAX[I_W-1:0];
            else if (int_shf < I_MIN)
                i_term = I_MIN[I_W-1:0];
            else
                i_term = int_shf[I_W-1:0];
        end else begin
            int_shf = integrator >>> 6;
            i_term  = int_shf[I_W-1:0];
        end
    end

    // Stage 2 sum and output saturation
    always_comb begin
        sum = SUM_W'(p_reg) + SUM_W'(i_term) + SUM_W'(d_reg);
        if (sum > OUT_MAX) begin
            sat_val  = OUT_MAX[OUT_W-1:0];
            sat_clip = 1'b1;
        end else if (sum < OUT_MIN) begin
            sat_val  = OUT_MIN[OUT_W-1:0];
            sat_clip = 1'b1;
        end else begin
            sat_val  = sum[OUT_W-1:0];
            sat_clip = 1'b0;
        end
    end

`ifdef SLEW_LMT_EN
    localparam logic signed [OUT_W:0] SLEW = (OUT_W + 1)'(SLEW_STEP);
    logic signed [OUT_W:0] slew_diff;

    // Step limited against the last emitted word, which IDLE/reset force to 0.
    always_comb begin
        slew_diff = (OUT_W + 1)'(sat_val) - (OUT_W + 1)'(PID_cntrl);
        out_nxt   = sat_val;
        sat_nxt   = sat_clip;
        if (slew_diff > SLEW) begin
            out_nxt = PID_cntrl + OUT_W'(SLEW_STEP);
            sat_nxt = 1'b1;
        end else if (slew_diff < -SLEW) begin
            out_nxt = PID_cntrl - OUT_W'(SLEW_STEP);
            sat_nxt = 1'b1;
        end
    end
`else
    assign out_nxt = sat_val;
    assign sat_nxt = sat_clip;
`endif

    // Power / soft-start FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmr <= '0;
                    if (pwr_up)
                        state <= RAMP;
                end
                RAMP: begin
                    if (!pwr_up) begin
                        state <= IDLE;
                        tmr   <= '0;
                    end else if (ss_full) begin
                        state <= RUN;
                    end else begin
                        tmr <= tmr + RAMP_STEP;
                    end
                end
                default: begin
                    if (!pwr_up) begin
                        state <= IDLE;
                        tmr   <= '0;
                    end
                end
            endcase
        end
    end

    // Two-stage datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integrator <= '0;
            p_reg      <= '0;
            d_reg      <= '0;
            s1_vld     <= 1'b0;
            PID_cntrl  <= '0;
            cntrl_vld  <= 1'b0;
            sat        <= 1'b0;
        end else if (!active) begin
            integrator <= '0;
            s1_vld     <= 1'b0;
            PID_cntrl  <= '0;
            cntrl_vld  <= 1'b0;
            sat        <= 1'b0;
        end else begin
            s1_vld    <= vld;
            cntrl_vld <= s1_vld;
            if (vld) begin
                p_reg <= p_nxt;
                d_reg <= d_nxt;
            end
            if (rider_off)
                integrator <= '0;
            else if (vld && !int_ovf)
                integrator <= int_sum;
            if (s1_vld) begin
                PID_cntrl <= out_nxt;
                sat       <= sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pid_cntrl_pipe.sv
// Directed bench for pid_cntrl_pipe: table of single-sample vectors plus
// sequences for accumulation, rider_off, power drop, soft-start and reset.
module tb_pid_cntrl_pipe;

  logic               clk;
  logic               rst_n;
  logic               vld;
  logic               pwr_up;
  logic               rider_off;
  logic [15:0]        ptch;
  logic [15:0]        ptch_rt;
  logic [5:0]         kp;
  logic [3:0]         d_shft;
  logic signed [11:0] pid_cntrl;
  logic               cntrl_vld;
  logic               sat;
  logic [7:0]         ss_tmr;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [15:0] ptch;
    logic [15:0] rt;
    logic [5:0]  kp;
    logic [3:0]  ds;
    int          exp_pid;
    logic        exp_sat;
  } vec_t;

  localparam int N_VEC = 15;
  vec_t vecs [N_VEC];

  pid_cntrl_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld),
    .pwr_up    (pwr_up),
    .rider_off (rider_off),
    .ptch      (ptch),
    .ptch_rt   (ptch_rt),
    .kp        (kp),
    .d_shft    (d_shft),
    .PID_cntrl (pid_cntrl),
    .cntrl_vld (cntrl_vld),
    .sat       (sat),
    .ss_tmr    (ss_tmr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_int();
    rider_off = 1'b1;
    @(negedge clk);
    rider_off = 1'b0;
  endtask

  // one sample in, checks the 2-cycle latency and the result
  task automatic run_vec(input string name, input logic [15:0] p, input logic [15:0] r,
                         input logic [5:0] k, input logic [3:0] ds,
                         input int exp_pid, input logic exp_sat);
    ptch    = p;
    ptch_rt = r;
    kp      = k;
    d_shft  = ds;
    vld     = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    check({name, "_vld_early"}, int'(cntrl_vld), 0);
    @(negedge clk);
    check({name, "_vld"}, int'(cntrl_vld), 1);
    check({name, "_pid"}, int'(pid_cntrl), exp_pid);
    check({name, "_sat"}, int'(sat), int'(exp_sat));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    vld       = 1'b0;
    pwr_up    = 1'b0;
    rider_off = 1'b0;
    ptch      = '0;
    ptch_rt   = '0;
    kp        = 6'd9;
    d_shft    = 4'd6;

    vecs[0]  = '{16'h0010, 16'h0000, 6'd9,  4'd6,   152, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0000, 6'd9,  4'd6,  2047, 1'b1};
    vecs[2]  = '{16'h0000, 16'h0400, 6'd9,  4'd6,   -16, 1'b0};
    vecs[3]  = '{16'hFFF0, 16'h0000, 6'd9,  4'd6,  -152, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0000, 6'd9,  4'd6, -2048, 1'b1};
    vecs[5]  = '{16'h0064, 16'h0200, 6'd9,  4'd6,   942, 1'b0};
    vecs[6]  = '{16'h0064, 16'h0000, 6'd0,  4'd6,    50, 1'b0};
    vecs[7]  = '{16'h0020, 16'h0000, 6'd63, 4'd6,  2032, 1'b0};
    vecs[8]  = '{16'h00D6, 16'hFC80, 6'd9,  4'd6,  2047, 1'b0};
    vecs[9]  = '{16'h00D6, 16'hFC40, 6'd9,  4'd6,  2047, 1'b1};
    vecs[10] = '{16'h0000, 16'h0064, 6'd9,  4'd0,  -100, 1'b0};
    vecs[11] = '{16'h0000, 16'h8000, 6'd9,  4'd15,    1, 1'b0};
    vecs[12] = '{16'h0000, 16'hC000, 6'd9,  4'd2, -2048, 1'b1};
    vecs[13] = '{16'hFF2A, 16'h03C0, 6'd9,  4'd6, -2048, 1'b0};
    vecs[14] = '{16'hFF2A, 16'h0400, 6'd9,  4'd6, -2048, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pid", int'(pid_cntrl), 0);
    check("rst_vld", int'(cntrl_vld), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_ss", int'(ss_tmr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // vld while IDLE is ignored
    vld  = 1'b1;
    ptch = 16'h0010;
    @(negedge clk);
    vld = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_vld", int'(cntrl_vld), 0);
    check("idle_pid", int'(pid_cntrl), 0);

    pwr_up = 1'b1;
    repeat (2) @(negedge clk);

    // table
    for (int i = 0; i < N_VEC; i++) begin
      clr_int();
      run_vec($sformatf("vec%0d", i), vecs[i].ptch, vecs[i].rt, vecs[i].kp, vecs[i].ds,
              vecs[i].exp_pid, vecs[i].exp_sat);
    end

    // integrator accumulates across samples
    clr_int();
    run_vec("acc1", 16'h0010, 16'h0000, 6'd9, 4'd6, 152, 1'b0);
    run_vec("acc2", 16'h0010, 16'h0000, 6'd9, 4'd6, 160, 1'b0);

    // rider_off wins over a same-cycle vld
    rider_off = 1'b1;
    run_vec("rider", 16'h0000, 16'h0000, 6'd9, 4'd6, 0, 1'b0);
    rider_off = 1'b0;
    run_vec("rider_next", 16'h0000, 16'h0000, 6'd9, 4'd6, 0, 1'b0);

    // back-to-back samples
    clr_int();
    ptch = 16'h0010;
    vld  = 1'b1;
    @(negedge clk);
    ptch = 16'h7FFF;
    check("b2b_early", int'(cntrl_vld), 0);
    @(negedge clk);
    vld = 1'b0;
    check("b2b_vld0", int'(cntrl_vld), 1);
    check("b2b_pid0", int'(pid_cntrl), 152);
    check("b2b_sat0", int'(sat), 0);
    @(negedge clk);
    check("b2b_vld1", int'(cntrl_vld), 1);
    check("b2b_pid1", int'(pid_cntrl), 2047);
    check("b2b_sat1", int'(sat), 1);
    @(negedge clk);
    check("b2b_end", int'(cntrl_vld), 0);

    // pwr_up drop with a sample in flight
    clr_int();
    run_vec("pre_drop", 16'h0010, 16'h0000, 6'd9, 4'd6, 152, 1'b0);
    ptch = 16'h0010;
    vld  = 1'b1;
    @(negedge clk);
    vld    = 1'b0;
    pwr_up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("drop_vld%0d", i), int'(cntrl_vld), 0);
    end
    check("drop_pid", int'(pid_cntrl), 0);
    check("drop_sat", int'(sat), 0);
    check("drop_ss", int'(ss_tmr), 0);

    // soft-start ramp from IDLE
    pwr_up = 1'b1;
    repeat (2048) @(negedge clk);
    check("ramp_2047", int'(ss_tmr), 0);
    @(negedge clk);
    check("ramp_2048", int'(ss_tmr), 1);
    repeat (2048) @(negedge clk);
    check("ramp_4096", int'(ss_tmr), 2);
    // integrator was cleared by IDLE, so no explicit clear here
    run_vec("ramp_run", 16'h0010, 16'h0000, 6'd9, 4'd6, 152, 1'b0);
    check("ramp_hold", int'(ss_tmr), 2);
    pwr_up = 1'b0;
    @(negedge clk);
    check("off_ss", int'(ss_tmr), 0);
    check("off_pid", int'(pid_cntrl), 0);

    // asynchronous reset mid-run
    pwr_up = 1'b1;
    repeat (2100) @(negedge clk);
    check("rerun_ss", int'(ss_tmr), 1);
    run_vec("rerun", 16'h0010, 16'h0000, 6'd9, 4'd6, 152, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_pid", int'(pid_cntrl), 0);
    check("mrst_vld", int'(cntrl_vld), 0);
    check("mrst_sat", int'(sat), 0);
    check("mrst_ss", int'(ss_tmr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ss", int'(ss_tmr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
